// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 decode encodings and ID/EX record type
package riscv_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] IMM_I   = 2'b00;
  localparam logic [1:0] IMM_S   = 2'b01;
  localparam logic [1:0] IMM_B   = 2'b10;
  localparam logic [1:0] IMM_J   = 2'b11;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

endpackage

// File: rtl/idecode_if.sv
// rtl/idecode_if.sv - decode-stage bus: IF/ID and writeback inputs, ID/EX outputs
interface idecode_if;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        FlushE;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two bypassing read ports, x0 hardwired
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic        we3,
  input  logic [4:0]  a3,
  input  logic [31:0] wd3,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];
  logic        wr_en;

  assign wr_en = we3 && (a3 != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[a3] <= wd3;
    end
  end

  // Writeback data is forwarded so decode sees a same-cycle write.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (a1 != 5'd0) rd1 = (wr_en && a3 == a1) ? wd3 : regs[a1];
    if (a2 != 5'd0) rd2 = (wr_en && a3 == a2) ? wd3 : regs[a2];
  end

endmodule

// File: rtl/idecode.sv
// rtl/idecode.sv - RV32 decode stage: control decode, immediate extend, ID/EX register
module idecode
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  idecode_if.slave   bus
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] instr;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [2:0]  alu_control;
  ctrl_t       ctrl;
  idex_t       ex_d;
  idex_t       ex_q;

  assign instr    = bus.InstrD;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign bus.Rs1D = instr[19:15];
  assign bus.Rs2D = instr[24:20];

  regfile u_rf (
    .clk   (clk),
    .reset (reset),
    .a1    (instr[19:15]),
    .a2    (instr[24:20]),
    .we3   (bus.RegWriteW),
    .a3    (bus.RdW),
    .wd3   (bus.ResultW),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_LW:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.result_src = RES_MEM;
                    ctrl.imm_src = IMM_I; ctrl.alu_op = ALUOP_ADD; end
      OP_SW:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1;
                    ctrl.imm_src = IMM_S; ctrl.alu_op = ALUOP_ADD; end
      OP_R:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALUOP_FUNC; end
      OP_I:   begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                    ctrl.imm_src = IMM_I; ctrl.alu_op = ALUOP_FUNC; end
      OP_BEQ: begin ctrl.branch = 1'b1; ctrl.imm_src = IMM_B; ctrl.alu_op = ALUOP_SUB; end
      OP_JAL: begin ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.result_src = RES_PC4;
                    ctrl.imm_src = IMM_J; ctrl.alu_op = ALUOP_ADD; end
      default: ctrl = '0;
    endcase
  end

  // Only R-type honours bit 30; addi must stay an add whatever its immediate holds.
  always_comb begin
    alu_control = ALU_ADD;
    case (ctrl.alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  alu_control = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    imm = '0;
    case (ctrl.imm_src)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    ex_d             = '0;
    ex_d.reg_write   = ctrl.reg_write;
    ex_d.mem_write   = ctrl.mem_write;
    ex_d.jump        = ctrl.jump;
    ex_d.branch      = ctrl.branch;
    ex_d.alu_src     = ctrl.alu_src;
    ex_d.result_src  = ctrl.result_src;
    ex_d.alu_control = alu_control;
    ex_d.rd1         = rd1;
    ex_d.rd2         = rd2;
    ex_d.imm         = imm;
    ex_d.pc          = bus.PCD;
    ex_d.pc_plus4    = bus.PCPlus4D;
    ex_d.rs1         = instr[19:15];
    ex_d.rs2         = instr[24:20];
    ex_d.rd          = instr[11:7];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else if (bus.FlushE) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.RegWriteE   = ex_q.reg_write;
  assign bus.MemWriteE   = ex_q.mem_write;
  assign bus.JumpE       = ex_q.jump;
  assign bus.BranchE     = ex_q.branch;
  assign bus.ALUSrcE     = ex_q.alu_src;
  assign bus.ResultSrcE  = ex_q.result_src;
  assign bus.ALUControlE = ex_q.alu_control;
  assign bus.RD1E        = ex_q.rd1;
  assign bus.RD2E        = ex_q.rd2;
  assign bus.ImmExtE     = ex_q.imm;
  assign bus.PCE         = ex_q.pc;
  assign bus.PCPlus4E    = ex_q.pc_plus4;
  assign bus.Rs1E        = ex_q.rs1;
  assign bus.Rs2E        = ex_q.rs2;
  assign bus.RdE         = ex_q.rd;

endmodule

// File: tb/tb_idecode.sv
// tb/tb_idecode.sv - directed self-checking bench for idecode
module tb_idecode;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  idecode_if bus ();

  idecode u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic we, input logic [4:0] rd,
                       input logic [31:0] res, input logic flush);
    bus.InstrD    = instr;
    bus.RegWriteW = we;
    bus.RdW       = rd;
    bus.ResultW   = res;
    bus.FlushE    = flush;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    bus.PCD      = 32'h0;
    bus.PCPlus4D = 32'h0;
    drive(32'h0050_0093, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("rst_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
    chk("rst_imm", bus.ImmExtE, 32'd0);
    tick();
    tick();
    chk("rst_held_rd", {27'd0, bus.RdE}, 32'd0);
    reset = 1'b0;

    // addi x1,x0,5
    bus.PCD      = 32'h0000_0100;
    bus.PCPlus4D = 32'h0000_0104;
    drive(32'h0050_0093, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("addi_regwrite", {31'd0, bus.RegWriteE}, 32'd1);
    chk("addi_alusrc", {31'd0, bus.ALUSrcE}, 32'd1);
    chk("addi_aluctl", {29'd0, bus.ALUControlE}, 32'd0);
    chk("addi_imm", bus.ImmExtE, 32'd5);
    chk("addi_rd", {27'd0, bus.RdE}, 32'd1);
    chk("addi_rd1", bus.RD1E, 32'd0);
    chk("addi_pc", bus.PCE, 32'h0000_0100);
    chk("addi_pc4", bus.PCPlus4E, 32'h0000_0104);

    // add x3,x1,x2 with same-cycle writeback of x2
    drive(32'h0020_81B3, 1'b1, 5'd2, 32'hDEAD_BEEF, 1'b0);
    #1;
    chk("rs1d_comb", {27'd0, bus.Rs1D}, 32'd1);
    chk("rs2d_comb", {27'd0, bus.Rs2D}, 32'd2);
    tick();
    chk("bypass_rd2", bus.RD2E, 32'hDEAD_BEEF);
    chk("add_alusrc", {31'd0, bus.ALUSrcE}, 32'd0);
    chk("add_rs2e", {27'd0, bus.Rs2E}, 32'd2);
    chk("add_rde", {27'd0, bus.RdE}, 32'd3);
    drive(32'h0020_81B3, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("stored_x2", bus.RD2E, 32'hDEAD_BEEF);

    // write to x0 must be ignored, including the bypass
    drive(32'h0000_01B3, 1'b1, 5'd0, 32'h0000_1234, 1'b0);
    tick();
    chk("x0_bypass", bus.RD1E, 32'd0);
    drive(32'h0000_01B3, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("x0_stored", bus.RD1E, 32'd0);

    // beq x0,x0,-4 and jal x0,8
    drive(32'hFE00_0EE3, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("beq_branch", {31'd0, bus.BranchE}, 32'd1);
    chk("beq_aluctl", {29'd0, bus.ALUControlE}, 32'd1);
    chk("beq_imm", bus.ImmExtE, 32'hFFFF_FFFC);
    chk("beq_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
    drive(32'h0080_006F, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("jal_jump", {31'd0, bus.JumpE}, 32'd1);
    chk("jal_ressrc", {30'd0, bus.ResultSrcE}, 32'd2);
    chk("jal_imm", bus.ImmExtE, 32'd8);
    chk("jal_aluctl", {29'd0, bus.ALUControlE}, 32'd0);

    // lw x4,12(x2)
    drive(32'h00C1_2203, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("lw_ressrc", {30'd0, bus.ResultSrcE}, 32'd1);
    chk("lw_imm", bus.ImmExtE, 32'd12);
    chk("lw_rd1", bus.RD1E, 32'hDEAD_BEEF);
    chk("lw_memwrite", {31'd0, bus.MemWriteE}, 32'd0);

    // R-type and I-ALU function decode
    drive(32'h4020_82B3, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    chk("sub_aluctl", {29'd0, bus.ALUControlE}, 32'd1);
    drive(32'h0020_A2B3, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    chk("slt_aluctl", {29'd0, bus.ALUControlE}, 32'd5);
    drive(32'h0020_F2B3, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    chk("and_aluctl", {29'd0, bus.ALUControlE}, 32'd2);
    drive(32'h0020_E2B3, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    chk("or_aluctl", {29'd0, bus.ALUControlE}, 32'd3);
    drive(32'h4000_0093, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    chk("addi_b30_aluctl", {29'd0, bus.ALUControlE}, 32'd0);
    chk("addi_b30_imm", bus.ImmExtE, 32'h0000_0400);
    drive(32'hFFF0_2093, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    chk("slti_aluctl", {29'd0, bus.ALUControlE}, 32'd5);
    chk("slti_imm", bus.ImmExtE, 32'hFFFF_FFFF);

    // unsupported opcode (lui)
    drive(32'h0000_0037, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    chk("bad_ctrl", {28'd0, bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE}, 32'd0);

    // sw x5,-8(x6) flushed, while x7 is written
    drive(32'hFE53_2C23, 1'b1, 5'd7, 32'h0000_0077, 1'b1);
    tick();
    chk("flush_memwrite", {31'd0, bus.MemWriteE}, 32'd0);
    chk("flush_imm", bus.ImmExtE, 32'd0);
    chk("flush_pc", bus.PCE, 32'd0);
    chk("flush_rs1e", {27'd0, bus.Rs1E}, 32'd0);
    drive(32'hFE53_2C23, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("sw_memwrite", {31'd0, bus.MemWriteE}, 32'd1);
    chk("sw_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
    chk("sw_imm", bus.ImmExtE, 32'hFFFF_FFF8);
    chk("sw_rs1e", {27'd0, bus.Rs1E}, 32'd6);
    drive(32'h0003_81B3, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("x7_written", bus.RD1E, 32'h0000_0077);

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_rd1", bus.RD1E, 32'd0);
    chk("async_rst_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
    chk("async_rst_pc4", bus.PCPlus4E, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("x7_cleared", bus.RD1E, 32'd0);
    chk("post_rst_regwrite", {31'd0, bus.RegWriteE}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/idecode.md
IDECODE -- requirements
Module: idecode

Interface
REQ-001 The block SHALL have no parameters; XLEN is fixed at 32 and the register file is fixed at 32 entries.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 InstrD  input  32  instruction from the IF/ID register.
REQ-005 PCD, PCPlus4D  input  32 each  PC and PC+4 from the IF/ID register.
REQ-006 RegWriteW  input  1  writeback enable.
REQ-007 RdW  input  5  writeback destination register.
REQ-008 ResultW  input  32  writeback data.
REQ-009 FlushE  input  1  synchronous clear of the ID/EX register (from hazard unit).
REQ-010 Rs1D, Rs2D  output  5 each  source register fields of the decode-stage instruction, combinational, for the hazard unit.
REQ-011 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered control signals.
REQ-012 ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4.
REQ-013 ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-014 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  32 each  registered operands, immediate and PCs.
REQ-015 Rs1E, Rs2E, RdE  output  5 each  registered register fields.

Function
REQ-016 Decode SHALL support lw(0000011), sw(0100011), R-type(0110011: add/sub/and/or/slt), I-ALU(0010011: addi/andi/ori/slti), beq(1100011), jal(1101111).
REQ-017 R-type sub SHALL be selected by funct3=000 with funct7[5]=1; addi SHALL always use add regardless of bit 30.
REQ-018 lw/sw/jal SHALL use ALUControl add; beq SHALL use sub.
REQ-019 Any unsupported opcode SHALL decode to all control outputs zero (RegWrite, MemWrite, Jump, Branch = 0).
REQ-020 Immediate SHALL be sign-extended from bit 31: I = [31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; J = {[19:12] at 19:12, [20] at 11, [30:21] at 10:1, 0}.
REQ-021 Register file SHALL have two combinational read ports (addresses InstrD[19:15], InstrD[24:20]) and one write port written on the rising edge when RegWriteW=1 and RdW!=0.
REQ-022 x0 SHALL always read 0; writes to x0 SHALL be ignored.
REQ-023 Read ports SHALL bypass: if RegWriteW=1, RdW!=0 and RdW equals the read address, the read returns ResultW in the same cycle.
REQ-024 ID/EX register SHALL capture all E outputs each rising edge, latency exactly one cycle from InstrD to E outputs.
REQ-025 FlushE=1 SHALL load all E outputs with 0 on the next edge, taking priority over capture; register-file write in that cycle SHALL still occur.

Reset
REQ-026 While reset=1 all E outputs SHALL be 0 and all 32 registers SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard any in-progress write and any pending capture.

Structure
REQ-028 Opcode constants, ALUControl, ResultSrc and ImmSrc encodings SHALL live in shared package riscv_pkg.
REQ-029 The register file SHALL be a separate sub-module named regfile; decoder, immediate extend and ID/EX register remain in idecode.

Verification
REQ-030 Reset then InstrD=0x00500093 (addi x1,x0,5) -> next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RdE=1, RD1E=0.
REQ-031 RegWriteW=1, RdW=2, ResultW=0xDEADBEEF while InstrD=0x002081B3 (add x3,x1,x2) -> RD2E=0xDEADBEEF next cycle (bypass).
REQ-032 RegWriteW=1, RdW=0, ResultW=0x1234 then read x0 -> RD1E=0.
REQ-033 InstrD=0xFE000EE3 (beq x0,x0,-4) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC; InstrD=0x0080006F (jal x0,8) -> JumpE=1, ResultSrcE=10, ImmExtE=8.
REQ-034 sw x5,-8(x6) (0xFE532C23) with FlushE=1 -> all E outputs 0; same instruction with FlushE=0 -> MemWriteE=1, RegWriteE=0, ImmExtE=0xFFFFFFF8.
REQ-035 Assert reset asynchronously between edges after writing x7 -> E outputs and x7 read 0 immediately.
